// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Package  : mem_pkg
// Brief    : Size codes, FSM encoding and lane helpers for the load/store unit.
// Revision : 1.0
// ----------------------------------------------------------------------------
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   localparam logic [1:0] SZ_RSVD = 2'd3;

   typedef logic [2:0] state_t;

   localparam state_t c_ST_IDLE    = 3'd0;
   localparam state_t c_ST_ACCESS  = 3'd1;
   localparam state_t c_ST_RELEASE = 3'd2;
   localparam state_t c_ST_DONE    = 3'd3;
   localparam state_t c_ST_ERR     = 3'd4;

   // Returns the lowest byte lane covered by the access; in big-endian mode a
   // halfword at offset 0 occupies lanes 3:2, so its base lane is 2.
   function automatic logic [1:0] lane_idx(input logic [1:0] off,
                                           input logic [1:0] size,
                                           input logic       big_endian);
      logic [1:0] lane;
      lane = 2'd0;
      case (size)
         SZ_BYTE: lane = big_endian ? (2'd3 - off) : off;
         SZ_HALF: lane = big_endian ? {~off[1], 1'b0} : {off[1], 1'b0};
         default: lane = 2'd0;
      endcase
      return lane;
   endfunction

   function automatic logic misaligned(input logic [1:0] off,
                                       input logic [1:0] size);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Interface : mem_access_unit_if
// Brief     : MOV/MOC memory bus between the load/store unit and memory.
// Revision  : 1.0
// ----------------------------------------------------------------------------
interface mem_access_unit_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              mov;
   logic              mrw;
   logic [ADDR_W-1:0] maddr;
   logic [3:0]        mbe;
   logic [DATA_W-1:0] mdata_out;
   logic [DATA_W-1:0] mdata_in;
   logic              moc;

   modport master (output mov, mrw, maddr, mbe, mdata_out,
                   input  mdata_in, moc);
   modport slave  (input  mov, mrw, maddr, mbe, mdata_out,
                   output mdata_in, moc);
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_lane_align.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mem_lane_align
// Brief    : Store replication, byte enables and load extract/extend.
// Revision : 1.0
// ----------------------------------------------------------------------------
module mem_lane_align
   import mem_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
)(
   input  logic [1:0]  i_offset,
   input  logic [1:0]  i_size,
   input  logic        i_sign_ld,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_mdata_in,
   output logic [3:0]  o_mbe,
   output logic [31:0] o_mdata_out,
   output logic [31:0] o_ldata
);
   logic [1:0]  w_lane;
   logic [15:0] w_low;

   assign w_lane = lane_idx(i_offset, i_size, BIG_ENDIAN);
   assign w_low  = 16'(i_mdata_in >> {w_lane, 3'b000});

   always_comb begin
      o_mbe       = 4'b0000;
      o_mdata_out = i_wdata;
      o_ldata     = i_mdata_in;
      case (i_size)
         SZ_BYTE: begin
            o_mbe       = 4'b0001 << w_lane;
            o_mdata_out = {4{i_wdata[7:0]}};
            o_ldata     = {{24{i_sign_ld & w_low[7]}}, w_low[7:0]};
         end
         SZ_HALF: begin
            o_mbe       = 4'b0011 << w_lane;
            o_mdata_out = {2{i_wdata[15:0]}};
            o_ldata     = {{16{i_sign_ld & w_low[15]}}, w_low};
         end
         SZ_WORD: begin
            o_mbe = 4'b1111;
         end
         default: begin
            o_mbe = 4'b0000;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : MAR/MDR load/store engine with MOV/MOC handshake and timeout.
// Revision : 1.0
// ----------------------------------------------------------------------------
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 16,
   parameter bit BIG_ENDIAN = 1'b1
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              rw,
   input  logic [1:0]        size,
   input  logic              sign_ld,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [DATA_W-1:0] wdata_in,
   mem_access_unit_if.master bus,
   output logic [DATA_W-1:0] rdata,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int                 c_CNT_W    = $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_mar;
   logic [DATA_W-1:0]   r_mdr;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_rw;
   logic                r_sign;
   logic [1:0]          r_size;
   logic [c_CNT_W-1:0]  r_cnt;
   logic [3:0]          w_mbe;
   logic [DATA_W-1:0]   w_mdata_out;
   logic [DATA_W-1:0]   w_ldata;
   logic                w_accept;

   assign w_accept = (r_state == c_ST_IDLE) && req;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // moc is checked before the counter so a completion on the last wait cycle wins.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (req) begin
               w_next_state = misaligned(addr_in[1:0], size) ? c_ST_ERR : c_ST_ACCESS;
            end
         end
         c_ST_ACCESS: begin
            if (bus.moc) begin
               w_next_state = c_ST_RELEASE;
            end else if (r_cnt == c_CNT_LAST) begin
               w_next_state = c_ST_ERR;
            end
         end
         c_ST_RELEASE: begin
            if (!bus.moc) begin
               w_next_state = c_ST_DONE;
            end
         end
         c_ST_DONE: w_next_state = c_ST_IDLE;
         c_ST_ERR:  w_next_state = c_ST_IDLE;
         default:   w_next_state = c_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mar   <= '0;
         r_mdr   <= '0;
         r_rw    <= 1'b0;
         r_sign  <= 1'b0;
         r_size  <= SZ_BYTE;
         r_cnt   <= '0;
         r_rdata <= '0;
      end else if (w_accept) begin
         r_mar  <= addr_in;
         r_mdr  <= wdata_in;
         r_rw   <= rw;
         r_sign <= sign_ld;
         r_size <= size;
         r_cnt  <= '0;
      end else if (r_state == c_ST_ACCESS) begin
         r_cnt <= r_cnt + 1'b1;
         if (bus.moc && r_rw) begin
            r_rdata <= w_ldata;
         end
      end
   end

   mem_lane_align #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_lane_align (
      .i_offset    (r_mar[1:0]),
      .i_size      (r_size),
      .i_sign_ld   (r_sign),
      .i_wdata     (r_mdr),
      .i_mdata_in  (bus.mdata_in),
      .o_mbe       (w_mbe),
      .o_mdata_out (w_mdata_out),
      .o_ldata     (w_ldata)
   );

   always_comb begin
      busy    = (r_state != c_ST_IDLE);
      bus.mov = (r_state == c_ST_ACCESS);
      done    = (r_state == c_ST_DONE) || (r_state == c_ST_ERR);
      err     = (r_state == c_ST_ERR);
      bus.mbe = (r_state == c_ST_IDLE) ? 4'b0000 : w_mbe;
   end

   assign bus.mrw       = r_rw;
   assign bus.maddr     = {r_mar[ADDR_W-1:2], 2'b00};
   assign bus.mdata_out = w_mdata_out;
   assign rdata         = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Brief    : Directed scoreboard bench for mem_access_unit (big-endian, TIMEOUT=16).
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
   import mem_pkg::*;

   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int TIMEOUT    = 16;
   localparam bit BIG_ENDIAN = 1'b1;

   logic        clk      = 1'b0;
   logic        reset    = 1'b0;
   logic        req      = 1'b0;
   logic        rw       = 1'b0;
   logic        sign_ld  = 1'b0;
   logic [1:0]  size     = 2'd0;
   logic [31:0] addr_in  = '0;
   logic [31:0] wdata_in = '0;
   logic [31:0] rdata;
   logic        busy;
   logic        done;
   logic        err;

   mem_access_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_access_unit #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .TIMEOUT    (TIMEOUT),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .rw       (rw),
      .size     (size),
      .sign_ld  (sign_ld),
      .addr_in  (addr_in),
      .wdata_in (wdata_in),
      .bus      (bus),
      .rdata    (rdata),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      int          lat;
      logic [31:0] rdata;
      logic        mov;
      logic [3:0]  mbe;
      logic [31:0] mdata;
      logic        mrw;
      logic [31:0] maddr;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic rw_i, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input int e_lat, input logic [31:0] e_rdata,
                        input logic e_mov, input logic [3:0] e_mbe, input logic [31:0] e_mdata);
      exp_t e;
      e.err   = e_err;
      e.lat   = e_lat;
      e.rdata = e_rdata;
      e.mov   = e_mov;
      e.mbe   = e_mbe;
      e.mdata = e_mdata;
      e.mrw   = rw_i;
      e.maddr = {a[31:2], 2'b00};
      sb.push_back(e);
      req      = 1'b1;
      rw       = rw_i;
      size     = sz;
      sign_ld  = sg;
      addr_in  = a;
      wdata_in = wd;
   endtask

   // Latency counts rising edges from the cycle req is driven to the cycle done is seen.
   task automatic complete(input int moc_delay, input logic [31:0] mem);
      exp_t        e;
      int          n;
      int          k;
      bit          got;
      bit          seen;
      logic [3:0]  c_mbe;
      logic [31:0] c_mdata;
      logic [31:0] c_maddr;
      logic        c_mrw;
      c_mbe = '0; c_mdata = '0; c_maddr = '0; c_mrw = 1'b0;
      @(posedge clk); #1;
      req = 1'b0;
      n = 1; k = 0; got = 1'b0; seen = 1'b0;
      while (!got && n < 60) begin
         if (bus.mov && !bus.moc) begin
            k++;
            if (moc_delay > 0 && k >= moc_delay) begin
               bus.moc      = 1'b1;
               bus.mdata_in = mem;
            end
         end else if (!bus.mov && bus.moc) begin
            bus.moc = 1'b0;
         end
         @(negedge clk);
         if (bus.mov && !seen) begin
            seen    = 1'b1;
            c_mbe   = bus.mbe;
            c_mdata = bus.mdata_out;
            c_maddr = bus.maddr;
            c_mrw   = bus.mrw;
         end
         if (done) got = 1'b1;
         else begin
            @(posedge clk); #1;
            n++;
         end
      end
      e = sb.pop_front();
      chk("done_seen", 32'(got), 32'd1);
      chk("latency", n, e.lat);
      chk("err", 32'(err), 32'(e.err));
      chk("rdata", rdata, e.rdata);
      chk("mov_seen", 32'(seen), 32'(e.mov));
      if (e.mov) begin
         chk("mbe", 32'(c_mbe), 32'(e.mbe));
         chk("mdata_out", c_mdata, e.mdata);
         chk("mrw", 32'(c_mrw), 32'(e.mrw));
         chk("maddr", c_maddr, e.maddr);
      end
      @(negedge clk);
      chk("done_pulse", 32'(done), 32'd0);
      bus.moc = 1'b0;
   endtask

   initial begin
      bus.moc      = 1'b0;
      bus.mdata_in = '0;
      #2;
      chk("rst_mov", 32'(bus.mov), 32'd0);
      chk("rst_mrw", 32'(bus.mrw), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_mbe", 32'(bus.mbe), 32'd0);
      chk("rst_maddr", bus.maddr, 32'd0);
      chk("rst_mdata_out", bus.mdata_out, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(posedge clk); #1; reset = 1'b1;

      // word load, fastest handshake
      @(posedge clk); #1;
      issue(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h11223344, 1'b0, 3, 32'hDEADBEEF, 1'b1, 4'b1111, 32'h11223344);
      complete(1, 32'hDEADBEEF);
      // byte store at 0x103
      @(posedge clk); #1;
      issue(1'b0, SZ_BYTE, 1'b0, 32'h103, 32'h000000A5, 1'b0, 3, 32'hDEADBEEF, 1'b1, 4'b0001, 32'hA5A5A5A5);
      complete(1, 32'h0);
      // signed and unsigned half loads at 0x102
      @(posedge clk); #1;
      issue(1'b1, SZ_HALF, 1'b1, 32'h102, 32'h0, 1'b0, 3, 32'hFFFFF00D, 1'b1, 4'b0011, 32'h0);
      complete(1, 32'h1234F00D);
      @(posedge clk); #1;
      issue(1'b1, SZ_HALF, 1'b0, 32'h102, 32'h0, 1'b0, 3, 32'h0000F00D, 1'b1, 4'b0011, 32'h0);
      complete(1, 32'h1234F00D);
      // misaligned word load
      @(posedge clk); #1;
      issue(1'b1, SZ_WORD, 1'b0, 32'h102, 32'h0, 1'b1, 1, 32'h0000F00D, 1'b0, 4'b0, 32'h0);
      complete(1, 32'h99999999);
      // signed byte load at 0x101 with slow memory
      @(posedge clk); #1;
      issue(1'b1, SZ_BYTE, 1'b1, 32'h101, 32'h0, 1'b0, 5, 32'hFFFFFF83, 1'b1, 4'b0100, 32'h0);
      complete(3, 32'h12835678);
      // half store at 0x100
      @(posedge clk); #1;
      issue(1'b0, SZ_HALF, 1'b0, 32'h100, 32'h0000BEEF, 1'b0, 3, 32'hFFFFFF83, 1'b1, 4'b1100, 32'hBEEFBEEF);
      complete(1, 32'h0);
      // reserved size and odd half address are errors
      @(posedge clk); #1;
      issue(1'b1, SZ_RSVD, 1'b0, 32'h100, 32'h0, 1'b1, 1, 32'hFFFFFF83, 1'b0, 4'b0, 32'h0);
      complete(1, 32'h77777777);
      @(posedge clk); #1;
      issue(1'b1, SZ_HALF, 1'b0, 32'h101, 32'h0, 1'b1, 1, 32'hFFFFFF83, 1'b0, 4'b0, 32'h0);
      complete(1, 32'h77777777);
      // timeout, then a late moc that must be ignored
      @(posedge clk); #1;
      issue(1'b1, SZ_WORD, 1'b0, 32'h200, 32'h0, 1'b1, TIMEOUT + 1, 32'hFFFFFF83, 1'b1, 4'b1111, 32'h0);
      complete(0, 32'h0);
      bus.moc      = 1'b1;
      bus.mdata_in = 32'h66666666;
      repeat (3) begin
         @(negedge clk);
         chk("late_moc_done", 32'(done), 32'd0);
         chk("late_moc_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1; bus.moc = 1'b0;
      // next request after the timeout proceeds normally
      @(posedge clk); #1;
      issue(1'b0, SZ_WORD, 1'b0, 32'h204, 32'hCAFEF00D, 1'b0, 3, 32'hFFFFFF83, 1'b1, 4'b1111, 32'hCAFEF00D);
      complete(1, 32'h0);
      // moc arrives on the last wait cycle: completion wins over timeout
      @(posedge clk); #1;
      issue(1'b1, SZ_WORD, 1'b0, 32'h208, 32'h0, 1'b0, TIMEOUT + 2, 32'h0BADCAFE, 1'b1, 4'b1111, 32'h0);
      complete(TIMEOUT, 32'h0BADCAFE);

      // reset during ACCESS
      @(posedge clk); #1;
      req = 1'b1; rw = 1'b1; size = SZ_WORD; addr_in = 32'h400;
      @(posedge clk); #1; req = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      chk("pre_reset_mov", 32'(bus.mov), 32'd1);
      reset = 1'b0;
      #1;
      chk("async_rst_mov", 32'(bus.mov), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_rdata", rdata, 32'd0);
      repeat (2) begin
         @(negedge clk);
         chk("rst_no_done", 32'(done), 32'd0);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      issue(1'b1, SZ_WORD, 1'b0, 32'h300, 32'h0, 1'b0, 3, 32'h55AA55AA, 1'b1, 4'b1111, 32'h0);
      complete(1, 32'h55AA55AA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
